// File: rtl/pio_in_pkg.sv
// Register map and edge-mode encoding shared by the PIO input capture block.
package pio_in_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA = 2'd0;
    localparam reg_addr_t ADDR_RSVD = 2'd1;
    localparam reg_addr_t ADDR_MASK = 2'd2;
    localparam reg_addr_t ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

endpackage

// File: rtl/avmm_pio_in_capture_if.sv
// Avalon-MM slave bus of the PIO input capture block (32-bit data, 2-bit word address).
interface avmm_pio_in_capture_if;
    import pio_in_pkg::*;

    reg_addr_t   address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/pio_sync_edge.sv
// Per-bit synchronizer chain, one-cycle delayed copy and edge detector for the PIO inputs.
module pio_sync_edge
    import pio_in_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] sync_data,
    output logic [DATA_W-1:0] edge_det
);

    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

    logic [DATA_W-1:0]      sync_p [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_p;
    logic [DATA_W-1:0]      dly_p;
    logic                   vld_dly;

    function automatic logic [DATA_W-1:0] detect(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] prev);
        case (MODE)
            EDGE_FALL: return ~cur & prev;
            EDGE_ANY:  return cur ^ prev;
            default:   return cur & ~prev;
        endcase
    endfunction

    // The valid bits mark which stages hold post-reset samples, so the zeros left by reset
    // never look like a transition while the chain refills.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            vld_p   <= '0;
            dly_p   <= '0;
            vld_dly <= 1'b0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            vld_p   <= {vld_p[SYNC_STAGES-2:0], 1'b1};
            dly_p   <= sync_p[SYNC_STAGES-1];
            vld_dly <= vld_p[SYNC_STAGES-1];
        end
    end

    assign sync_data = sync_p[SYNC_STAGES-1];
    assign edge_det  = vld_dly ? detect(sync_data, dly_p) : '0;

endmodule

// File: rtl/avmm_pio_in_capture.sv
// Avalon-MM PIO input port with optional edge capture and level interrupt.
// Edge capture, interrupt mask and irq exist only when PIO_IN_EDGE_CAPTURE_EN is defined.
module avmm_pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    avmm_pio_in_capture_if.slave  bus,
    input  logic [DATA_W-1:0]     in_port,
    output logic                  irq
);

    logic [DATA_W-1:0] sync_data;
    logic [DATA_W-1:0] edge_det;
    logic [DATA_W-1:0] irq_mask;
    logic [DATA_W-1:0] edge_capture;
    logic              wr_en;

    pio_sync_edge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .sync_data (sync_data),
        .edge_det  (edge_det)
    );

    assign wr_en = bus.chipselect && !bus.write_n;

`ifdef PIO_IN_EDGE_CAPTURE_EN
    logic [DATA_W-1:0] edge_clr;

    assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[DATA_W-1:0] : '0;

    // A fresh edge is OR-ed in after the clear, so it wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_MASK) irq_mask <= bus.writedata[DATA_W-1:0];
            edge_capture <= (edge_capture & ~edge_clr) | edge_det;
        end
    end

    assign irq = |(edge_capture & irq_mask);
`else
    assign irq_mask     = '0;
    assign edge_capture = '0;
    assign irq          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_DATA: bus.readdata <= 32'(sync_data);
                ADDR_RSVD: bus.readdata <= '0;
                ADDR_MASK: bus.readdata <= 32'(irq_mask);
                ADDR_EDGE: bus.readdata <= 32'(edge_capture);
            endcase
        end
    end

    // Upper writedata bits and, in the reduced build, the whole write path have no sink.
    logic unused_ok;
    assign unused_ok = ^{bus.writedata, edge_det, wr_en};

endmodule

// File: tb/tb_avmm_pio_in_capture.sv
// Bench for avmm_pio_in_capture: two instances (rising / any-edge) against a sample-history model.
module tb_avmm_pio_in_capture;
    import pio_in_pkg::*;

    localparam int DW = 24;
    localparam int S  = 2;
`ifdef PIO_IN_EDGE_CAPTURE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [DW-1:0] in_port    = '0;
    logic          irq0, irq2;
    int            errs   = 0;
    int            checks = 0;
    bit            chk_en = 1'b0;

    always #5 clk = ~clk;

    avmm_pio_in_capture_if bus0 ();
    avmm_pio_in_capture_if bus2 ();
    assign bus0.address = address;    assign bus2.address = address;
    assign bus0.chipselect = chipselect; assign bus2.chipselect = chipselect;
    assign bus0.write_n = write_n;    assign bus2.write_n = write_n;
    assign bus0.writedata = writedata; assign bus2.writedata = writedata;

    avmm_pio_in_capture #(.DATA_W(DW), .SYNC_STAGES(S), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
    avmm_pio_in_capture #(.DATA_W(DW), .SYNC_STAGES(S), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in_port samples since reset release, newest first. The data register shows the
    // sample taken S edges ago; a change between two consecutive post-reset samples sets the
    // capture bit S edges after the later sample. Index 0 = rising-edge DUT, 1 = any-edge DUT.
    logic [DW-1:0] hq[$];
    logic [DW-1:0] m_mask = '0;
    logic [DW-1:0] m_cap[2] = '{'0, '0};
    logic [31:0]   exp_rd[2] = '{32'd0, 32'd0};
    logic          exp_irq[2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_sync, m_clr, m_ev, m_cur, m_prev;
    logic          m_we;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hq.delete();
            m_mask = '0;
            for (int m = 0; m < 2; m++) begin
                m_cap[m] = '0; exp_rd[m] = '0; exp_irq[m] = 1'b0;
            end
        end else begin
            hq.push_front(in_port);
            if (hq.size() > S + 2) void'(hq.pop_back());
            m_sync = (hq.size() > S) ? hq[S] : '0;
            m_we   = chipselect && !write_n;
            m_clr  = (EDGE_EN && m_we && address == ADDR_EDGE) ? writedata[DW-1:0] : '0;
            for (int m = 0; m < 2; m++) begin
                case (address)
                    ADDR_DATA: exp_rd[m] = 32'(m_sync);
                    ADDR_MASK: exp_rd[m] = 32'(m_mask);
                    ADDR_EDGE: exp_rd[m] = 32'(m_cap[m]);
                    default:   exp_rd[m] = 32'd0;
                endcase
                m_ev = '0;
                if (EDGE_EN && hq.size() >= S + 2) begin
                    m_cur  = hq[S];
                    m_prev = hq[S+1];
                    m_ev   = (m == 0) ? (m_cur & ~m_prev) : (m_cur ^ m_prev);
                end
                m_cap[m] = (m_cap[m] & ~m_clr) | m_ev;
            end
            if (EDGE_EN && m_we && address == ADDR_MASK) m_mask = writedata[DW-1:0];
            for (int m = 0; m < 2; m++) exp_irq[m] = |(m_cap[m] & m_mask);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd0",  bus0.readdata, exp_rd[0]);
            chk("model_irq0", {31'd0, irq0}, {31'd0, exp_irq[0]});
            chk("model_rd2",  bus2.readdata, exp_rd[1]);
            chk("model_irq2", {31'd0, irq2}, {31'd0, exp_irq[1]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [1:0] keep;
        keep = address;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = keep;
    endtask

    localparam logic [31:0] ON = EDGE_EN ? 32'd1 : 32'd0;

    initial begin
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_rd0", bus0.readdata, 32'd0);
        chk("reset_irq0", {31'd0, irq0}, 32'd0);
        chk("reset_rd2", bus2.readdata, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(5);

        // Data path latency
        in_port = 24'hA5A5A5;
        cyc(S);
        chk("data_early", bus0.readdata, 32'd0);
        cyc(1);
        chk("data_a5", bus0.readdata, 32'h00A5A5A5);
        in_port = '0;
        cyc(6);

        // Rising edge on bit 0 with mask bit 0, then clear
        wr(ADDR_MASK, 32'h1);
        address = ADDR_EDGE;
        in_port = 24'h000001;
        cyc(2);
        chk("irq_before_capture", {31'd0, irq0}, 32'd0);
        cyc(1);
        chk("irq_on_capture", {31'd0, irq0}, ON);
        cyc(1);
        chk("cap_bit0", bus0.readdata, ON);
        wr(ADDR_EDGE, 32'h1);
        chk("irq_after_clear", {31'd0, irq0}, 32'd0);
        cyc(1);
        chk("cap_cleared", bus0.readdata, 32'd0);

        // Clear and new edge on bit 3 in the same cycle
        in_port = in_port | 24'h8;
        cyc(4);
        in_port = in_port & ~24'h8;
        cyc(4);
        in_port = in_port | 24'h8;
        cyc(S);
        wr(ADDR_EDGE, 32'h8);
        cyc(1);
        chk("edge_beats_clear", bus0.readdata, EDGE_EN ? 32'h8 : 32'h0);
        wr(ADDR_EDGE, 32'h8);
        cyc(1);
        chk("plain_clear", bus0.readdata, 32'd0);

        // Any-edge pulse on bit 5 with mask off, then unmask
        wr(ADDR_MASK, 32'h0);
        in_port = in_port | 24'h20;
        cyc(3);
        in_port = in_port & ~24'h20;
        cyc(4);
        chk("pulse_cap2", bus2.readdata, EDGE_EN ? 32'h20 : 32'h0);
        chk("pulse_irq2_masked", {31'd0, irq2}, 32'd0);
        wr(ADDR_MASK, 32'h20);
        chk("pulse_irq2_unmasked", {31'd0, irq2}, ON);

        // Full capture, then asynchronous reset mid-cycle with a write in flight
        in_port = '0;
        cyc(6);
        wr(ADDR_EDGE, 32'hFFFFFFFF);
        in_port = 24'h0000FF;
        cyc(6);
        wr(ADDR_MASK, 32'hFF);
        cyc(1);
        chk("cap_ff", bus0.readdata, EDGE_EN ? 32'hFF : 32'h0);
        chk("irq_ff", {31'd0, irq0}, ON);
        @(posedge clk);
        #2 address = ADDR_MASK; writedata = 32'h00FF00FF; chipselect = 1'b1; write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd0", bus0.readdata, 32'd0);
        chk("async_irq0", {31'd0, irq0}, 32'd0);
        chk("async_rd2", bus2.readdata, 32'd0);
        chk("async_irq2", {31'd0, irq2}, 32'd0);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = ADDR_EDGE;
        cyc(2);
        reset_n = 1'b1;
        cyc(8);
        chk("no_spurious_cap0", bus0.readdata, 32'd0);
        chk("no_spurious_cap2", bus2.readdata, 32'd0);
        address = ADDR_MASK;
        cyc(1);
        chk("mask_after_reset", bus0.readdata, 32'd0);

        // Upper bits ignored, reserved/disabled registers read zero
        wr(ADDR_MASK, 32'hFFFFFFFF);
        wr(ADDR_EDGE, 32'hFFFFFFFF);
        cyc(1);
        chk("mask_zero_ext", bus0.readdata, EDGE_EN ? 32'h00FFFFFF : 32'h0);
        address = ADDR_EDGE;
        cyc(1);
        chk("edge_all_clear", bus0.readdata, 32'd0);
        chk("irq_idle", {31'd0, irq0}, 32'd0);
        wr(ADDR_RSVD, 32'hFFFFFFFF);
        wr(ADDR_DATA, 32'h12345678);
        address = ADDR_RSVD;
        cyc(1);
        chk("rsvd_zero", bus0.readdata, 32'd0);
        address = ADDR_DATA;
        cyc(1);
        chk("data_ff", bus0.readdata, 32'h000000FF);

        // Randomized traffic with one reset pulse
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) in_port = in_port ^ DW'($urandom & $urandom);
            address = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) begin
                chipselect = ($urandom_range(3) != 0);
                write_n    = ($urandom_range(3) == 0);
                writedata  = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
            end else begin
                chipselect = 1'($urandom_range(1));
                write_n    = 1'b1;
            end
            if (i == 300) #2 reset_n = 1'b0;
            if (i == 304) reset_n = 1'b1;
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        cyc(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
